vx_afu_ctrl: RTL and testbench

AXI4-Lite control-register slave that sits directly downstream of the accelerator's `s_axi_ctrl_*` host port, inside the AFU wrapper. It decodes host register reads and writes into kernel control (`ap_start`/done/idle/ready), interrupt enable/status, device capability readback, DCR write commands, and per-bank memory base addresses. Its outputs drive the Vortex processor start logic and the interrupt line to the shell.

---
 rtl/vx_afu_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_vx_afu_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_afu_ctrl.sv
// vx_afu_ctrl - AXI4-Lite control-register slave for the Vortex AFU.
//
// Decodes host register accesses into kernel control (ap_start / done /
// idle / ready), interrupt enable and status, capability readback, DCR
// write commands and per-bank memory base addresses.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   s_axi_ctrl_aw*/w*/b*  AXI4-Lite write address / data / response
//   s_axi_ctrl_ar*/r*     AXI4-Lite read address / data
//   ap_start              kernel start request (out)
//   ap_ready, ap_done     kernel handshake pulses (in)
//   ap_idle               kernel idle level (in)
//   interrupt             level interrupt = GIE & |ISR
//   dcr_wr_valid/addr/data  one-cycle DCR write command
//   mem_base              bank i base address in bits [64i+63:64i]
module vx_afu_ctrl #(
  parameter int          AXI_ADDR_WIDTH = 8,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_NUM_BANKS  = 2,
  parameter logic [63:0] DEV_CAPS       = 64'h0,
  parameter logic [63:0] ISA_CAPS       = 64'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_axi_ctrl_awvalid,
  output logic                        s_axi_ctrl_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_ctrl_awaddr,
  input  logic                        s_axi_ctrl_wvalid,
  output logic                        s_axi_ctrl_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_ctrl_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_ctrl_wstrb,
  input  logic                        s_axi_ctrl_arvalid,
  output logic                        s_axi_ctrl_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_ctrl_araddr,
  output logic                        s_axi_ctrl_rvalid,
  input  logic                        s_axi_ctrl_rready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_ctrl_rdata,
  output logic [1:0]                  s_axi_ctrl_rresp,
  output logic                        s_axi_ctrl_bvalid,
  input  logic                        s_axi_ctrl_bready,
  output logic [1:0]                  s_axi_ctrl_bresp,
  output logic                        ap_start,
  input  logic                        ap_ready,
  input  logic                        ap_done,
  input  logic                        ap_idle,
  output logic                        interrupt,
  output logic                        dcr_wr_valid,
  output logic [31:0]                 dcr_wr_addr,
  output logic [31:0]                 dcr_wr_data,
  output logic [64*AXI_NUM_BANKS-1:0] mem_base
);

  localparam int WW = AXI_ADDR_WIDTH - 2;  // word-index width

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_t;

  wr_state_t r_wr_state;
  rd_state_t r_rd_state;
  logic      r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [WW-1:0]             r_aw_word;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic        r_ap_start, r_auto_restart, r_done, r_ready, r_gie;
  logic [1:0]  r_ier, r_isr;
  logic [31:0] r_dcr_addr, r_dcr_data;
  logic        r_dcr_wr_valid;

  logic [31:0]               w_wr_idx, w_rd_idx;
  logic                      w_w_hs, w_ar_hs, w_clr_ctrl;
  logic [1:0]                w_isr_next;
  logic [AXI_DATA_WIDTH-1:0] w_rd_val;
  logic [31:0]               w_bank_words [2*AXI_NUM_BANKS];
  logic                      w_unused;

  // Byte-lane merge for registers that honour wstrb.
  function automatic logic [AXI_DATA_WIDTH-1:0] f_merge(
    input logic [AXI_DATA_WIDTH-1:0]   old_val,
    input logic [AXI_DATA_WIDTH-1:0]   new_val,
    input logic [AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < AXI_DATA_WIDTH/8; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  // addr[1:0] are ignored by the word-aligned map
  assign w_unused   = &{1'b0, s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};
  assign w_wr_idx   = 32'(r_aw_word);
  assign w_rd_idx   = 32'(s_axi_ctrl_araddr[AXI_ADDR_WIDTH-1:2]);
  assign w_w_hs     = (r_wr_state == WRDATA) && s_axi_ctrl_wvalid;
  assign w_ar_hs    = (r_rd_state == RDIDLE) && s_axi_ctrl_arvalid;
  assign w_clr_ctrl = w_ar_hs && (w_rd_idx == 32'd0);

  // Write channel FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WRRESET;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_aw_word  <= '0;
    end else begin
      case (r_wr_state)
        WRRESET: begin
          r_wr_state <= WRIDLE;
          r_awready  <= 1'b1;
        end
        WRIDLE: if (s_axi_ctrl_awvalid) begin
          r_aw_word  <= s_axi_ctrl_awaddr[AXI_ADDR_WIDTH-1:2];
          r_wr_state <= WRDATA;
          r_awready  <= 1'b0;
          r_wready   <= 1'b1;
        end
        WRDATA: if (s_axi_ctrl_wvalid) begin
          r_wr_state <= WRRESP;
          r_wready   <= 1'b0;
          r_bvalid   <= 1'b1;
        end
        WRRESP: if (s_axi_ctrl_bready) begin
          r_wr_state <= WRIDLE;
          r_bvalid   <= 1'b0;
          r_awready  <= 1'b1;
        end
        default: r_wr_state <= WRRESET;
      endcase
    end
  end

  // Read channel FSM; rdata is captured on the AR handshake and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= RDRESET;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        RDRESET: begin
          r_rd_state <= RDIDLE;
          r_arready  <= 1'b1;
        end
        RDIDLE: if (s_axi_ctrl_arvalid) begin
          r_rdata    <= w_rd_val;
          r_rd_state <= RDDATA;
          r_arready  <= 1'b0;
          r_rvalid   <= 1'b1;
        end
        RDDATA: if (s_axi_ctrl_rready) begin
          r_rd_state <= RDIDLE;
          r_rvalid   <= 1'b0;
          r_arready  <= 1'b1;
        end
        default: r_rd_state <= RDRESET;
      endcase
    end
  end

  // ISR: host write toggles, kernel events set; a set beats a toggle.
  always_comb begin
    w_isr_next = r_isr;
    if (w_w_hs && (w_wr_idx == 32'd3) && s_axi_ctrl_wstrb[0])
      w_isr_next = r_isr ^ s_axi_ctrl_wdata[1:0];
    if (ap_done && r_ier[0])  w_isr_next[0] = 1'b1;
    if (ap_ready && r_ier[1]) w_isr_next[1] = 1'b1;
  end

  // Control and DCR registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ap_start     <= 1'b0;
      r_auto_restart <= 1'b0;
      r_done         <= 1'b0;
      r_ready        <= 1'b0;
      r_gie          <= 1'b0;
      r_ier          <= 2'b00;
      r_isr          <= 2'b00;
      r_dcr_addr     <= '0;
      r_dcr_data     <= '0;
      r_dcr_wr_valid <= 1'b0;
    end else begin
      // the event term is ORed last so a coincident read-clear loses
      r_done  <= (r_done & ~w_clr_ctrl) | ap_done;
      r_ready <= (r_ready & ~w_clr_ctrl) | ap_ready;
      r_isr   <= w_isr_next;
      // a host start request wins over a same-cycle ap_ready clear
      if (w_w_hs && (w_wr_idx == 32'd0) && s_axi_ctrl_wstrb[0] && s_axi_ctrl_wdata[0])
        r_ap_start <= 1'b1;
      else if (ap_ready && !r_auto_restart)
        r_ap_start <= 1'b0;
      r_dcr_wr_valid <= w_w_hs && (w_wr_idx == 32'd9);
      if (w_w_hs) begin
        case (w_wr_idx)
          32'd0: if (s_axi_ctrl_wstrb[0]) r_auto_restart <= s_axi_ctrl_wdata[7];
          32'd1: if (s_axi_ctrl_wstrb[0]) r_gie <= s_axi_ctrl_wdata[0];
          32'd2: if (s_axi_ctrl_wstrb[0]) r_ier <= s_axi_ctrl_wdata[1:0];
          32'd8: r_dcr_addr <= f_merge(r_dcr_addr, s_axi_ctrl_wdata, s_axi_ctrl_wstrb);
          32'd9: r_dcr_data <= s_axi_ctrl_wdata;
          default: ;
        endcase
      end
    end
  end

  // Per-bank memory base registers: lo word at 0x40+8i, hi word at 0x44+8i.
  genvar gi;
  generate
    for (gi = 0; gi < AXI_NUM_BANKS; gi++) begin : g_bank
      logic [31:0] r_lo, r_hi;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lo <= '0;
          r_hi <= '0;
        end else if (w_w_hs) begin
          if (w_wr_idx == 32'(16 + 2*gi))
            r_lo <= f_merge(r_lo, s_axi_ctrl_wdata, s_axi_ctrl_wstrb);
          if (w_wr_idx == 32'(17 + 2*gi))
            r_hi <= f_merge(r_hi, s_axi_ctrl_wdata, s_axi_ctrl_wstrb);
        end
      end
      assign mem_base[64*gi +: 64] = {r_hi, r_lo};
      assign w_bank_words[2*gi]     = r_lo;
      assign w_bank_words[2*gi + 1] = r_hi;
    end
  endgenerate

  // Read decode; unmapped and write-only addresses return 0.
  always_comb begin
    w_rd_val = '0;
    case (w_rd_idx)
      32'd0: w_rd_val = {24'd0, r_auto_restart, 3'd0, r_ready, ap_idle, r_done, r_ap_start};
      32'd1: w_rd_val = {31'd0, r_gie};
      32'd2: w_rd_val = {30'd0, r_ier};
      32'd3: w_rd_val = {30'd0, r_isr};
      32'd4: w_rd_val = DEV_CAPS[31:0];
      32'd5: w_rd_val = DEV_CAPS[63:32];
      32'd6: w_rd_val = ISA_CAPS[31:0];
      32'd7: w_rd_val = ISA_CAPS[63:32];
      32'd8: w_rd_val = r_dcr_addr;
      default: begin
        for (int i = 0; i < 2*AXI_NUM_BANKS; i++)
          if (w_rd_idx == 32'(16 + i)) w_rd_val = w_bank_words[i];
      end
    endcase
  end

  assign s_axi_ctrl_awready = r_awready;
  assign s_axi_ctrl_wready  = r_wready;
  assign s_axi_ctrl_bvalid  = r_bvalid;
  assign s_axi_ctrl_bresp   = 2'b00;
  assign s_axi_ctrl_arready = r_arready;
  assign s_axi_ctrl_rvalid  = r_rvalid;
  assign s_axi_ctrl_rdata   = r_rdata;
  assign s_axi_ctrl_rresp   = 2'b00;
  assign ap_start           = r_ap_start;
  assign interrupt          = r_gie & (|r_isr);
  assign dcr_wr_valid       = r_dcr_wr_valid;
  assign dcr_wr_addr        = r_dcr_addr;
  assign dcr_wr_data        = r_dcr_data;

endmodule

// File: tb/tb_vx_afu_ctrl.sv
// Testbench for vx_afu_ctrl: directed scenarios with literal expectations,
// then concurrent randomized AXI traffic and kernel events, all checked each
// cycle against a register-map level reference model.
module tb_vx_afu_ctrl;
  localparam int          NB   = 2;
  localparam logic [63:0] DEVC = 64'h1122_3344_5566_7788;
  localparam logic [63:0] ISAC = 64'h99AA_BBCC_DDEE_FF00;
  localparam int          TMO  = 200;

  logic clk = 1'b0;
  logic reset;
  logic awvalid, awready, wvalid, wready, arvalid, arready;
  logic rvalid, rready, bvalid, bready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;
  logic ap_start, ap_ready, ap_done, ap_idle, interrupt;
  logic dcr_wr_valid;
  logic [31:0] dcr_wr_addr, dcr_wr_data;
  logic [64*NB-1:0] mem_base;

  vx_afu_ctrl #(.AXI_ADDR_WIDTH(8), .AXI_DATA_WIDTH(32), .AXI_NUM_BANKS(NB),
                .DEV_CAPS(DEVC), .ISA_CAPS(ISAC)) dut (
    .clk(clk), .reset(reset),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_wstrb(wstrb),
    .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready), .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready), .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp),
    .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready), .s_axi_ctrl_bresp(bresp),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .interrupt(interrupt), .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr),
    .dcr_wr_data(dcr_wr_data), .mem_base(mem_base)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dcr_pulses = 0;
  logic stop_ctl;

  // Reference model: register contents plus channel phase
  // (0 = post-reset, 1 = idle, 2 = data/wait, 3 = response).
  int          m_wph, m_rph, m_awword;
  logic        m_start, m_auto, m_done, m_ready, m_gie, m_dcr_v;
  logic [1:0]  m_ier, m_isr;
  logic [31:0] m_dcr_a, m_dcr_d, m_rdata;
  logic [31:0] m_mem [2*NB];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: handshake not seen within %0d cycles at %0t", nm, TMO, $time);
  endtask

  function automatic int wrd(input logic [7:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_read(input int w);
    case (w)
      0: return {24'd0, m_auto, 3'd0, m_ready, ap_idle, m_done, m_start};
      1: return {31'd0, m_gie};
      2: return {30'd0, m_ier};
      3: return {30'd0, m_isr};
      4: return DEVC[31:0];
      5: return DEVC[63:32];
      6: return ISAC[31:0];
      7: return ISAC[63:32];
      8: return m_dcr_a;
      default: return (w >= 16 && w < 16 + 2*NB) ? m_mem[w-16] : 32'd0;
    endcase
  endfunction

  task automatic mdl_reset();
    m_wph = 0; m_rph = 0; m_awword = 0;
    m_start = 0; m_auto = 0; m_done = 0; m_ready = 0; m_gie = 0; m_dcr_v = 0;
    m_ier = 0; m_isr = 0; m_dcr_a = 0; m_dcr_d = 0; m_rdata = 0;
    for (int i = 0; i < 2*NB; i++) m_mem[i] = 0;
  endtask

  // Called on every falling edge: compare, then advance the model to the
  // state it must hold after the coming rising edge.
  task automatic mon_step();
    logic [127:0] exp_mb;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, clr0, n_start;
    logic [1:0] n_isr;
    exp_mb = '0;
    for (int i = 0; i < NB; i++) exp_mb[64*i +: 64] = {m_mem[2*i+1], m_mem[2*i]};
    chk("awready", awready, m_wph == 1);
    chk("wready", wready, m_wph == 2);
    chk("bvalid", bvalid, m_wph == 3);
    chk("arready", arready, m_rph == 1);
    chk("rvalid", rvalid, m_rph == 2);
    chk("rdata", rdata, m_rdata);
    chk("resp", {rresp, bresp}, 4'd0);
    chk("ap_start", ap_start, m_start);
    chk("interrupt", interrupt, m_gie & (|m_isr));
    chk("dcr_valid", dcr_wr_valid, m_dcr_v);
    chk("dcr_addr", dcr_wr_addr, m_dcr_a);
    chk("dcr_data", dcr_wr_data, m_dcr_d);
    chk("mem_base", mem_base, exp_mb);
    if (dcr_wr_valid) dcr_pulses++;

    if (reset) begin
      mdl_reset();
      return;
    end
    ar_hs = arvalid && m_rph == 1;
    r_hs  = rready  && m_rph == 2;
    aw_hs = awvalid && m_wph == 1;
    w_hs  = wvalid  && m_wph == 2;
    b_hs  = bready  && m_wph == 3;

    if (ar_hs) m_rdata = mdl_read(wrd(araddr));
    clr0 = ar_hs && wrd(araddr) == 0;

    n_isr = m_isr;
    if (w_hs && m_awword == 3 && wstrb[0]) n_isr = n_isr ^ wdata[1:0];
    if (ap_done && m_ier[0]) n_isr[0] = 1'b1;
    if (ap_ready && m_ier[1]) n_isr[1] = 1'b1;

    n_start = m_start;
    if (ap_ready && !m_auto) n_start = 1'b0;
    if (w_hs && m_awword == 0 && wstrb[0] && wdata[0]) n_start = 1'b1;

    m_dcr_v = w_hs && m_awword == 9;
    if (w_hs) begin
      case (m_awword)
        0: if (wstrb[0]) m_auto = wdata[7];
        1: if (wstrb[0]) m_gie = wdata[0];
        2: if (wstrb[0]) m_ier = wdata[1:0];
        8: m_dcr_a = merge(m_dcr_a, wdata, wstrb);
        9: m_dcr_d = wdata;
        default: if (m_awword >= 16 && m_awword < 16 + 2*NB)
                   m_mem[m_awword-16] = merge(m_mem[m_awword-16], wdata, wstrb);
      endcase
    end
    m_done  = (m_done && !clr0) || ap_done;
    m_ready = (m_ready && !clr0) || ap_ready;
    m_isr   = n_isr;
    m_start = n_start;

    if (aw_hs) m_awword = wrd(awaddr);
    case (m_wph)
      0: m_wph = 1;
      1: if (aw_hs) m_wph = 2;
      2: if (w_hs) m_wph = 3;
      default: if (b_hs) m_wph = 1;
    endcase
    case (m_rph)
      0: m_rph = 1;
      1: if (ar_hs) m_rph = 2;
      default: if (r_hs) m_rph = 1;
    endcase
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int bdly);
    int t;
    @(posedge clk); #1;
    awvalid = 1; awaddr = a;
    t = 0; @(negedge clk);
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo_fail("aw_timeout");
    @(posedge clk); #1;
    awvalid = 0; wvalid = 1; wdata = d; wstrb = s;
    t = 0; @(negedge clk);
    while (!wready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo_fail("w_timeout");
    @(posedge clk); #1;
    wvalid = 0;
    if (bdly > 0) begin repeat (bdly) @(posedge clk); #1; end
    bready = 1;
    t = 0; @(negedge clk);
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo_fail("b_timeout");
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, input int rdly, output logic [31:0] d);
    int t;
    @(posedge clk); #1;
    arvalid = 1; araddr = a;
    t = 0; @(negedge clk);
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo_fail("ar_timeout");
    @(posedge clk); #1;
    arvalid = 0;
    if (rdly > 0) begin repeat (rdly) @(posedge clk); #1; end
    rready = 1;
    t = 0; @(negedge clk);
    while (!rvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo_fail("r_timeout");
    d = rdata;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 ap_ready = 1;
    @(posedge clk); #1 ap_ready = 0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 ap_done = 1;
    @(posedge clk); #1 ap_done = 0;
  endtask

  function automatic logic [7:0] rand_addr();
    int words [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19};
    if ($urandom_range(0, 3) == 3) return 8'($urandom);
    return 8'(words[$urandom_range(0, 13)] * 4 + $urandom_range(0, 3));
  endfunction

  task automatic main_seq();
    logic [31:0] d;
    int p0;
    reset = 1; ap_idle = 1; ap_ready = 0; ap_done = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; bready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    repeat (3) @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("arready_first_cycle", arready, 1'b0);
    @(negedge clk);
    chk("arready_second_cycle", arready, 1'b1);
    rd(8'h00, 0, d); chk("rd_ctrl_after_reset", d, 32'h4);
    rd(8'h10, 0, d); chk("rd_devcaps_lo", d, 32'h5566_7788);
    rd(8'h1C, 0, d); chk("rd_isacaps_hi", d, 32'h99AA_BBCC);

    wr(8'h00, 32'h1, 4'hF, 0);  @(negedge clk); chk("start_set", ap_start, 1'b1);
    pulse_ready();              @(negedge clk); chk("start_clr_on_ready", ap_start, 1'b0);
    wr(8'h00, 32'h81, 4'hF, 0);
    pulse_ready();              @(negedge clk); chk("start_auto_restart", ap_start, 1'b1);
    wr(8'h00, 32'h0, 4'hF, 0);  @(negedge clk); chk("start_write0_noeffect", ap_start, 1'b1);
    pulse_ready();              @(negedge clk); chk("start_clr_after_auto_off", ap_start, 1'b0);

    wr(8'h04, 32'h1, 4'hF, 0);
    wr(8'h08, 32'h1, 4'hF, 0);
    pulse_done();               @(negedge clk); chk("irq_on_done", interrupt, 1'b1);
    rd(8'h0C, 0, d); chk("isr_after_done", d, 32'h1);
    rd(8'h00, 0, d); chk("done_bit_first_read", d[1], 1'b1);
    rd(8'h00, 0, d); chk("done_bit_second_read", d[1], 1'b0);
    wr(8'h0C, 32'h1, 4'hF, 0);  @(negedge clk); chk("irq_cleared_by_toggle", interrupt, 1'b0);

    p0 = dcr_pulses;
    wr(8'h20, 32'h5, 4'hF, 0);
    wr(8'h24, 32'hDEAD_BEEF, 4'hF, 0);
    repeat (3) @(negedge clk);
    chk("dcr_pulse_count", dcr_pulses - p0, 1);
    chk("dcr_addr_lit", dcr_wr_addr, 32'h5);
    chk("dcr_data_lit", dcr_wr_data, 32'hDEAD_BEEF);

    wr(8'h48, 32'h1000, 4'hF, 0);
    wr(8'h4C, 32'hFFFF_0002, 4'b0011, 0);
    @(negedge clk); chk("mem_base1_strb", mem_base[127:64], 64'h0000_0002_0000_1000);

    wr(8'h40, 32'hCAFE_0001, 4'hF, 5);
    rd(8'h48, 5, d); chk("rd_backpressure", d, 32'h1000);
    rd(8'h24, 0, d); chk("rd_dcr_data_wo", d, 32'h0);

    stop_ctl = 0;
    fork
      begin
        fork
          for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            wr(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3));
          end
          begin
            logic [31:0] d2;
            for (int j = 0; j < 150; j++) rd(rand_addr(), $urandom_range(0, 3), d2);
          end
        join
        stop_ctl = 1;
      end
      begin
        while (!stop_ctl) begin
          @(posedge clk); #1;
          ap_done  = ($urandom_range(0, 5) == 0);
          ap_ready = ($urandom_range(0, 5) == 0);
          ap_idle  = 1'($urandom);
        end
        ap_done = 0; ap_ready = 0; ap_idle = 1;
      end
    join

    // Abandon a write mid-transaction with reset.
    wr(8'h00, 32'h1, 4'hF, 0);
    wr(8'h04, 32'h1, 4'hF, 0);
    wr(8'h08, 32'h3, 4'hF, 0);
    pulse_done();
    @(posedge clk); #1 awvalid = 1; awaddr = 8'h44;
    begin
      int t;
      t = 0; @(negedge clk);
      while (!awready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) tmo_fail("aw_timeout_rst");
    end
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk); chk("wready_before_reset", wready, 1'b1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wready", wready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_ap_start", ap_start, 1'b0);
    chk("rst_interrupt", interrupt, 1'b0);
    chk("rst_mem_base", mem_base, 128'd0);
    chk("rst_dcr_addr", dcr_wr_addr, 32'd0);
    @(posedge clk); #1 reset = 0;
    rd(8'h40, 0, d); chk("rd_mem_after_reset", d, 32'h0);
    rd(8'h00, 0, d); chk("rd_ctrl_after_reset2", d, 32'h4);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    mdl_reset();
    reset = 1;
    fork
      begin
        @(posedge clk);
        forever begin
          @(negedge clk);
          mon_step();
        end
      end
      main_seq();
      begin
        #500000;
        tmo_fail("global_timeout");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
